// File: rtl/torque_ramp_controller.sv
// Torque ramp sequencer: steps applied torque toward the commanded level once per tick,
// forcing torque to 0 before any direction change, with estop and HOLD watchdog handling.
module torque_ramp_controller #(
    parameter int unsigned TICK_CYCLES   = 5000000,
    parameter int unsigned MAX_TORQUE    = 4,
    parameter int unsigned TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_instruction,
    input  logic [2:0] cmd_torque,
    input  logic       estop,
    output logic       enable,
    output logic [1:0] instruction,
    output logic [2:0] torque,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam int unsigned WW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_TICKS);
    localparam logic [2:0]    MAX_T      = 3'(MAX_TORQUE);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, ESTOP} state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] presc_q;
    logic [WW-1:0] wd_q, wd_n, wd_inc;
    logic [1:0]    tgt_instr_q, tgt_instr_n, instr_n;
    logic [2:0]    tgt_torque_q, tgt_torque_n, torque_n, cmd_clamped;
    logic          timeout_n, tick, accept, differs;

    // Free-running step prescaler; commands never restart it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else if (presc_q == PRESC_LAST) presc_q <= '0;
        else presc_q <= presc_q + PW'(1);
    end

    assign tick        = (presc_q == PRESC_LAST);
    assign cmd_clamped = (cmd_torque > MAX_T) ? MAX_T : cmd_torque;
    assign accept      = cmd_valid && cmd_ready && !estop;
    assign differs     = (cmd_instruction != instruction) || (cmd_clamped != torque);
    assign wd_inc      = wd_q + WW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            tgt_instr_q  <= 2'b00;
            tgt_torque_q <= 3'd0;
            instruction  <= 2'b00;
            torque       <= 3'd0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
            cmd_ready    <= 1'b1;
        end else begin
            state_q      <= state_n;
            wd_q         <= wd_n;
            tgt_instr_q  <= tgt_instr_n;
            tgt_torque_q <= tgt_torque_n;
            instruction  <= instr_n;
            torque       <= torque_n;
            enable       <= (state_n == RAMP) || (state_n == HOLD);
            busy         <= (state_n == RAMP);
            timeout      <= timeout_n;
            cmd_ready    <= (state_n != ESTOP);
        end
    end

    // Next state: estop wins, then the tick step (old target), then command accept
    always_comb begin
        state_n      = state_q;
        wd_n         = wd_q;
        tgt_instr_n  = tgt_instr_q;
        tgt_torque_n = tgt_torque_q;
        instr_n      = instruction;
        torque_n     = torque;
        timeout_n    = 1'b0;

        if (estop) begin
            state_n      = ESTOP;
            torque_n     = 3'd0;
            tgt_instr_n  = 2'b00;
            tgt_torque_n = 3'd0;
            wd_n         = '0;
        end else begin
            unique case (state_q)
                IDLE: torque_n = 3'd0;
                RAMP: begin
                    if (tick) begin
                        if (instruction != tgt_instr_q) begin
                            if (torque != 3'd0) torque_n = torque - 3'd1;
                            else instr_n = tgt_instr_q;
                        end else if (torque < tgt_torque_q) begin
                            torque_n = torque + 3'd1;
                        end else if (torque > tgt_torque_q) begin
                            torque_n = torque - 3'd1;
                        end else begin
                            state_n = (torque != 3'd0) ? HOLD : IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (wd_inc == WD_LAST) begin
                            wd_n         = '0;
                            tgt_torque_n = 3'd0;
                            timeout_n    = 1'b1;
                            state_n      = RAMP;
                        end else begin
                            wd_n = wd_inc;
                        end
                    end
                end
                ESTOP: begin
                    torque_n = 3'd0;
                    state_n  = IDLE;
                end
            endcase

            if (accept) begin
                tgt_instr_n  = cmd_instruction;
                tgt_torque_n = cmd_clamped;
                wd_n         = '0;
                timeout_n    = 1'b0;
                if (state_q == IDLE) state_n = (cmd_clamped != 3'd0) ? RAMP : IDLE;
                else state_n = differs ? RAMP : state_q;
            end
        end
    end

endmodule

// File: tb/tb_torque_ramp_controller.sv
// Directed bench for torque_ramp_controller; expected output words are queued as stimulus
// is applied and compared when the DUT responds.
module tb_torque_ramp_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_instruction = 2'b00;
    logic [2:0] cmd_torque = 3'd0;
    logic       estop = 1'b0;
    logic       enable;
    logic [1:0] instruction;
    logic [2:0] torque;
    logic       busy;
    logic       timeout;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [8:0]  exp_q[$];
    string       tag_q[$];
    logic [1:0]  pc;

    torque_ramp_controller #(.TICK_CYCLES(4), .MAX_TORQUE(4), .TIMEOUT_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instruction(cmd_instruction), .cmd_torque(cmd_torque), .estop(estop),
        .enable(enable), .instruction(instruction), .torque(torque), .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference prescaler phase: a step happens on the edge where pc is 3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 2'd0;
        else pc <= pc + 2'd1;
    end

    function automatic logic [8:0] ev(input bit en, input bit bz, input bit rdy, input bit tmo,
                                      input logic [1:0] ins, input logic [2:0] tq);
        return {en, bz, rdy, tmo, ins, tq};
    endfunction

    task automatic push(input string t, input logic [8:0] e);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic chk();
        logic [8:0] obs, e;
        string t;
        obs = {enable, busy, cmd_ready, timeout, instruction, torque};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %b required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_bad++;
                $error("FAIL %s: observed en/bz/rdy/tmo/ins/tq=%b required %b", t, obs, e);
            end
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (pc != 2'd3 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            n_cmp++;
            n_bad++;
            $error("FAIL tick_wait: observed no step edge within 8 cycles, required one");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tk(input string t, input logic [8:0] e);
        push(t, e);
        wait_tick();
        chk();
    endtask

    task automatic cyc(input string t, input logic [8:0] e);
        push(t, e);
        @(posedge clk);
        #1;
        chk();
    endtask

    task automatic cmd(input logic [1:0] ins, input logic [2:0] tq, input string t,
                       input logic [8:0] e);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_instruction = ins;
        cmd_torque = tq;
        cyc(t, e);
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        push("reset", ev(0, 0, 1, 0, 2'b00, 3'd0));
        chk();
        @(negedge clk);
        rst_n = 1'b1;

        // fwd/3 from IDLE
        cmd(2'b00, 3'd3, "t1_accept", ev(1, 1, 1, 0, 2'b00, 3'd0));
        tk("t1_up1", ev(1, 1, 1, 0, 2'b00, 3'd1));
        tk("t1_up2", ev(1, 1, 1, 0, 2'b00, 3'd2));
        tk("t1_up3", ev(1, 1, 1, 0, 2'b00, 3'd3));
        tk("t1_hold", ev(1, 0, 1, 0, 2'b00, 3'd3));

        // Reversal to back/2 goes through torque 0 before switching
        cmd(2'b01, 3'd2, "t2_accept", ev(1, 1, 1, 0, 2'b00, 3'd3));
        tk("t2_dn2", ev(1, 1, 1, 0, 2'b00, 3'd2));
        tk("t2_dn1", ev(1, 1, 1, 0, 2'b00, 3'd1));
        tk("t2_dn0", ev(1, 1, 1, 0, 2'b00, 3'd0));
        tk("t2_switch", ev(1, 1, 1, 0, 2'b01, 3'd0));
        tk("t2_up1", ev(1, 1, 1, 0, 2'b01, 3'd1));
        tk("t2_up2", ev(1, 1, 1, 0, 2'b01, 3'd2));
        tk("t2_hold", ev(1, 0, 1, 0, 2'b01, 3'd2));

        // left/7 is clamped to 4
        cmd(2'b10, 3'd7, "t3_accept", ev(1, 1, 1, 0, 2'b01, 3'd2));
        tk("t3_dn1", ev(1, 1, 1, 0, 2'b01, 3'd1));
        tk("t3_dn0", ev(1, 1, 1, 0, 2'b01, 3'd0));
        tk("t3_switch", ev(1, 1, 1, 0, 2'b10, 3'd0));
        for (int i = 1; i <= 4; i++)
            tk($sformatf("t3_up%0d", i), ev(1, 1, 1, 0, 2'b10, 3'(i)));
        tk("t3_hold", ev(1, 0, 1, 0, 2'b10, 3'd4));

        // right/2, then watchdog timeout
        cmd(2'b11, 3'd2, "t4_accept", ev(1, 1, 1, 0, 2'b10, 3'd4));
        for (int i = 3; i >= 0; i--)
            tk($sformatf("t4_dn%0d", i), ev(1, 1, 1, 0, 2'b10, 3'(i)));
        tk("t4_switch", ev(1, 1, 1, 0, 2'b11, 3'd0));
        tk("t4_up1", ev(1, 1, 1, 0, 2'b11, 3'd1));
        tk("t4_up2", ev(1, 1, 1, 0, 2'b11, 3'd2));
        tk("t4_hold", ev(1, 0, 1, 0, 2'b11, 3'd2));
        tk("t4_wd1", ev(1, 0, 1, 0, 2'b11, 3'd2));
        tk("t4_wd2", ev(1, 0, 1, 0, 2'b11, 3'd2));
        tk("t4_timeout", ev(1, 1, 1, 1, 2'b11, 3'd2));
        cyc("t4_pulse_end", ev(1, 1, 1, 0, 2'b11, 3'd2));
        tk("t4_dn1", ev(1, 1, 1, 0, 2'b11, 3'd1));
        tk("t4_dn0", ev(1, 1, 1, 0, 2'b11, 3'd0));
        tk("t4_idle", ev(0, 0, 1, 0, 2'b11, 3'd0));

        // Estop mid-ramp with a command pending
        cmd(2'b00, 3'd3, "t5_accept", ev(1, 1, 1, 0, 2'b11, 3'd0));
        tk("t5_switch", ev(1, 1, 1, 0, 2'b00, 3'd0));
        tk("t5_up1", ev(1, 1, 1, 0, 2'b00, 3'd1));
        tk("t5_up2", ev(1, 1, 1, 0, 2'b00, 3'd2));
        @(negedge clk);
        estop = 1'b1;
        cmd_valid = 1'b1;
        cmd_instruction = 2'b01;
        cmd_torque = 3'd4;
        cyc("t5_estop", ev(0, 0, 0, 0, 2'b00, 3'd0));
        cyc("t5_estop_hold", ev(0, 0, 0, 0, 2'b00, 3'd0));
        @(negedge clk);
        estop = 1'b0;
        cyc("t5_release", ev(0, 0, 1, 0, 2'b00, 3'd0));
        @(negedge clk);
        cmd_valid = 1'b0;
        tk("t5_still1", ev(0, 0, 1, 0, 2'b00, 3'd0));
        tk("t5_still2", ev(0, 0, 1, 0, 2'b00, 3'd0));

        // Async reset mid-ramp, then fwd/1
        cmd(2'b10, 3'd3, "t6_accept", ev(1, 1, 1, 0, 2'b00, 3'd0));
        tk("t6_switch", ev(1, 1, 1, 0, 2'b10, 3'd0));
        tk("t6_up1", ev(1, 1, 1, 0, 2'b10, 3'd1));
        #2;
        rst_n = 1'b0;
        #1;
        push("t6_async_reset", ev(0, 0, 1, 0, 2'b00, 3'd0));
        chk();
        @(negedge clk);
        rst_n = 1'b1;
        cmd(2'b00, 3'd1, "t6_fwd1_accept", ev(1, 1, 1, 0, 2'b00, 3'd0));
        tk("t6_fwd1_up1", ev(1, 1, 1, 0, 2'b00, 3'd1));
        tk("t6_fwd1_hold", ev(1, 0, 1, 0, 2'b00, 3'd1));

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_drain: observed %0d left over, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/torque_ramp_controller.md
Name: torque_ramp_controller

Overview:
Sequencer that drives the torque display/motor-command path: accepts a commanded direction and torque level and ramps the displayed/applied torque toward it one step per tick. A direction change always ramps torque down to 0 before the instruction switches. It provides emergency-stop and command-timeout handling, and outputs the enable, instruction and torque bus consumed downstream by the torque display.

Parameters:
TICK_CYCLES, 5000000, clock cycles per ramp step (0.1 s at 50 MHz); legal range is 2 or more.
MAX_TORQUE, 4, highest legal torque level; commands above it are clamped.
TIMEOUT_TICKS, 20, ticks in HOLD without a new command before an automatic ramp to 0.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge
cmd_instruction  in  2  00 fwd, 01 back, 10 left, 11 right
cmd_torque  in  3  target level 0..MAX_TORQUE
estop  in  1  level-sensitive emergency stop, synchronous sample
enable  out  1  downstream enable
instruction  out  2  current applied direction
torque  out  3  current applied level
busy  out  1  high while state is RAMP
timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_n low, async): enable=0, instruction=00, torque=0, busy=0, timeout=0, cmd_ready=1, target_instr=00, target_torque=0, prescaler=0, watchdog=0, state=IDLE.
- Prescaler: free-running 0..TICK_CYCLES-1. tick=1 for the single cycle when the count equals TICK_CYCLES-1. Only reset clears it; commands do not restart it.
- Command accept:
  - Accepted when cmd_valid && cmd_ready.
  - Latch target_instr=cmd_instruction and target_torque=min(cmd_torque, MAX_TORQUE).
  - Clear the watchdog.
  - Next state: RAMP if the new target differs from (instruction, torque), else unchanged.
  - cmd_ready = (state != ESTOP) && !estop.
  - A new command overrides any in-flight ramp.
- States:
  - IDLE: enable=0, torque=0. On accept: RAMP, or stay IDLE if target_torque=0.
  - RAMP: enable=1, busy=1. On each tick, apply exactly one action, in priority order:
    (a) instruction != target_instr and torque > 0: torque - 1.
    (b) instruction != target_instr and torque = 0: instruction <= target_instr, torque unchanged.
    (c) torque < target_torque: torque + 1.
    (d) torque > target_torque: torque - 1.
    (e) torque = target_torque: go to HOLD if torque > 0, else IDLE.
  - HOLD: enable=1. On each tick, watchdog + 1. When watchdog reaches TIMEOUT_TICKS: target_torque <= 0, timeout pulse, go to RAMP. Watchdog is only active in HOLD.
  - ESTOP: enable=0, torque=0, cmd_ready=0, targets cleared to 0. instruction holds its value. Go to IDLE on the first cycle estop is sampled low.
- Estop: when estop is sampled high in any state, the next cycle is ESTOP with torque=0. It has priority over command accept, tick and watchdog. A cmd_valid in the same cycle is not accepted.
- Simultaneous accept and tick: the tick step uses the pre-accept target. The new target takes effect from the next tick.
- Outputs are registered. Torque changes by at most 1 per tick, except on the estop forced-to-0 step.
- A full direction reversal from level N to level M takes N+1+M ticks to settle: N down-steps, 1 switch tick, M up-steps. It then takes one further tick to reach HOLD.

Test Plan:
1. TICK_CYCLES=4. Command fwd/3 from IDLE -> torque 1,2,3 on ticks 1-3. busy high in RAMP, HOLD on tick 4, enable=1, instruction=00.
2. From HOLD fwd/3, command back/2 -> torque 2,1,0, then instruction=01, then torque 1,2, then HOLD. Torque never nonzero while instruction mismatches the target.
3. Command left/7 -> target clamped to 4; torque ramps to 4 and holds.
4. HOLD at right/2, TIMEOUT_TICKS=3, no commands -> timeout pulse 1 cycle after 3 ticks, torque ramps 1,0, then IDLE with enable=0.
5. Assert estop mid-ramp at torque 2 with cmd_valid high -> next cycle torque=0, enable=0, cmd_ready=0, command not accepted. Deassert estop -> IDLE, cmd_ready=1, no motion.
6. Assert rst_n low mid-RAMP at a non-edge time -> all outputs at reset values immediately. Command fwd/1 after release -> torque=1 on the first tick.
